bit_serial_adder: RTL and testbench

//  Multi-bit adder built around the team's 1-bit full-adder cell: one bit per clock, LSB first.

---
 rtl/bit_serial_adder_pkg.sv | 19 +
 rtl/bit_serial_adder_fa_cell.sv | 13 +
 rtl/bit_serial_adder.sv | 138 +++++++++++++
 tb/tb_bit_serial_adder.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// Optional feature macro used by the top: BIT_SERIAL_ADDER_OVF_EN.
package bit_serial_adder_pkg;

  // Controller states; encodings are fixed so waveforms read the same across builds.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Bit-counter width for a given operand width, never less than one bit.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bit_serial_adder_fa_cell.sv
// Combinational 1-bit full adder, the only arithmetic in the bit-serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder cell, one bit per clock, LSB first.
// Operands come in over a valid/ready handshake, the {cout,sum} result leaves
// over another. A result appears WIDTH clocks after the accepting edge.
// Optional macro BIT_SERIAL_ADDER_OVF_EN adds the signed-overflow output ovf.
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef BIT_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_bit;
  logic             fa_s;
  logic             fa_co;

  assign accept   = in_valid && (state == IDLE);
  assign last_bit = (state == RUN) && (cnt == LAST_BIT);

  // The new sum bit enters at the MSB end so that after WIDTH shifts the LSB sits at bit 0.
  assign sum_next = (sum_sh >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  fa_cell u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: accept only in IDLE, finish on the last bit, release on out_ready.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept)    next_state = RUN;
      RUN:     if (last_bit)  next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default:                next_state = IDLE;
    endcase
  end

  // Operand shifters, carry flop, bit counter and the held result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            sum_sh <= '0;
            carry  <= cin;
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_next;
          carry  <= fa_co;
          cnt    <= cnt + CNT_W'(1);
          if (last_bit) begin
            sum_q  <= sum_next;
            cout_q <= fa_co;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef BIT_SERIAL_ADDER_OVF_EN
  logic carry_msb_q;

  // Remember the carry entering the MSB; overflow is that carry differing from cout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_msb_q <= 1'b0;
    end else if (last_bit) begin
      carry_msb_q <= carry;
    end
  end

  assign ovf = carry_msb_q ^ cout_q;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: an 8-bit instance checked through a
// scoreboard of expected results, plus a 1-bit instance for the truth-table test.
// Honours BIT_SERIAL_ADDER_OVF_EN when the build defines it.
module tb_bit_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  logic in_valid1;
  logic in_ready1;
  logic a1;
  logic b1;
  logic cin1;
  logic out_valid1;
  logic out_ready1;
  logic sum1;
  logic cout1;
  logic ovf1;

  int tests_run = 0;
  int fails     = 0;

  logic [W+1:0] sb[$];
  logic [W+1:0] exp_res;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef BIT_SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  bit_serial_adder #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .cout      (cout1)
`ifdef BIT_SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf1)
`endif
  );

`ifndef BIT_SERIAL_ADDER_OVF_EN
  assign ovf  = 1'b0;
  assign ovf1 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: {ovf, cout, sum} from plain wide addition and the sign rule.
  function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic cv);
    logic [W:0] t;
    logic       o;
    t = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    o = (av[W-1] == bv[W-1]) && (t[W-1] != av[W-1]);
    return {o, t};
  endfunction

  // Scoreboard: every completed output handshake is popped and compared.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      tests_run++;
      if (sb.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_result: got sum=%h cout=%b, required no result", sum, cout);
      end else begin
        exp_res = sb.pop_front();
        if ({cout, sum} !== exp_res[W:0]) begin
          fails++;
          $display("[TB] FAIL result: got cout=%b sum=%h, required cout=%b sum=%h",
                   cout, sum, exp_res[W], exp_res[W-1:0]);
        end
`ifdef BIT_SERIAL_ADDER_OVF_EN
        tests_run++;
        if (ovf !== exp_res[W+1]) begin
          fails++;
          $display("[TB] FAIL ovf: got %b, required %b", ovf, exp_res[W+1]);
        end
`endif
      end
    end
  end

  // Present one operand pair and hold it until the accepting edge; track=1 queues the result.
  task automatic accept_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                           input bit track);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL accept_timeout: got in_ready=%b, required 1", in_ready);
    end
    a        = av;
    b        = bv;
    cin      = cv;
    in_valid = 1'b1;
    if (track) sb.push_back(model(av, bv, cv));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    cin      = 1'($urandom_range(0, 1));
  endtask

  // Count edges from the accepting edge until out_valid is seen, bounded.
  task automatic wait_result(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    int lat;
    out_ready = 1'b1;
    accept_op(8'h12, 8'h34, 1'b0, 1'b1);
    wait_result(lat);
    @(posedge clk);
    #1;
    accept_op(8'h55, 8'h22, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    tests_run++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_out_valid: got %b, required 0", out_valid);
    end
    tests_run++;
    if (sum !== 8'h00 || cout !== 1'b0 || ovf !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_result: got sum=%h cout=%b ovf=%b, required 00 0 0", sum, cout, ovf);
    end
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_carry_wrap();
    int lat;
    out_ready = 1'b1;
    accept_op(8'hFF, 8'h01, 1'b0, 1'b1);
    wait_result(lat);
    tests_run++;
    if (lat != W) begin
      fails++;
      $display("[TB] FAIL wrap_latency: got %0d, required %0d", lat, W);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL wrap_release: got out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    tests_run++;
    if (sum !== 8'h00 || cout !== 1'b1) begin
      fails++;
      $display("[TB] FAIL wrap_hold: got sum=%h cout=%b, required 00 1", sum, cout);
    end
  endtask

  task automatic test_overflow();
    int lat;
    out_ready = 1'b1;
    accept_op(8'h7F, 8'h00, 1'b1, 1'b1);
    wait_result(lat);
    tests_run++;
    if (lat != W || sum !== 8'h80 || cout !== 1'b0) begin
      fails++;
      $display("[TB] FAIL ovf_pos: got lat=%0d sum=%h cout=%b, required %0d 80 0", lat, sum, cout, W);
    end
    @(posedge clk);
    #1;
    accept_op(8'h80, 8'h80, 1'b0, 1'b1);
    wait_result(lat);
    tests_run++;
    if (lat != W || sum !== 8'h00 || cout !== 1'b1) begin
      fails++;
      $display("[TB] FAIL ovf_neg: got lat=%0d sum=%h cout=%b, required %0d 00 1", lat, sum, cout, W);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_stall();
    int lat;
    int bad;
    out_ready = 1'b0;
    accept_op(8'h12, 8'h34, 1'b0, 1'b1);
    wait_result(lat);
    tests_run++;
    if (lat != W) begin
      fails++;
      $display("[TB] FAIL stall_latency: got %0d, required %0d", lat, W);
    end
    a        = 8'hAA;
    b        = 8'h01;
    cin      = 1'b0;
    in_valid = 1'b1;
    bad      = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (sum !== 8'h46 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      fails++;
      $display("[TB] FAIL stall_hold: got %0d disturbed cycles (sum=%h), required 0", bad, sum);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL stall_release: got out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
    sb.push_back(model(8'hAA, 8'h01, 1'b0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tests_run++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL stall_reaccept: got in_ready=%b, required 0", in_ready);
    end
    wait_result(lat);
    tests_run++;
    if (lat != W) begin
      fails++;
      $display("[TB] FAIL reaccept_latency: got %0d, required %0d", lat, W);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int pulses;
    out_ready = 1'b1;
    accept_op(8'h33, 8'h44, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midrun_reset: got in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    @(posedge clk);
    #1;
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) pulses++;
    end
    tests_run++;
    if (pulses != 0) begin
      fails++;
      $display("[TB] FAIL midrun_pulse: got %0d out_valid cycles, required 0", pulses);
    end
    @(posedge clk);
    #1;
    accept_op(8'h0F, 8'hF0, 1'b1, 1'b1);
    wait_result(lat);
    tests_run++;
    if (lat != W || sum !== 8'h00 || cout !== 1'b1) begin
      fails++;
      $display("[TB] FAIL after_reset: got lat=%0d sum=%h cout=%b, required %0d 00 1", lat, sum, cout, W);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      accept_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      wait_result(lat);
      tests_run++;
      if (lat != W) begin
        fails++;
        $display("[TB] FAIL b2b_latency[%0d]: got %0d, required %0d", i, lat, W);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_width1();
    int expv;
    int bad;
    bad        = 0;
    out_ready1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a1        = 1'((i >> 2) & 1);
      b1        = 1'((i >> 1) & 1);
      cin1      = 1'(i & 1);
      expv      = ((i >> 2) & 1) + ((i >> 1) & 1) + (i & 1);
      in_valid1 = 1'b1;
      @(posedge clk);
      #1;
      in_valid1 = 1'b0;
      @(posedge clk);
      #1;
      tests_run++;
      if (out_valid1 !== 1'b1 || {cout1, sum1} !== 2'(expv)) begin
        fails++;
        $display("[TB] FAIL w1_combo[%0d]: got valid=%b {cout,sum}=%b, required 1 %0d",
                 i, out_valid1, {cout1, sum1}, expv);
      end
`ifdef BIT_SERIAL_ADDER_OVF_EN
      tests_run++;
      if (ovf1 !== ((a1 == b1) && (sum1 != a1))) begin
        fails++;
        $display("[TB] FAIL w1_ovf[%0d]: got %b", i, ovf1);
      end
`endif
      @(posedge clk);
      #1;
      if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      fails++;
      $display("[TB] FAIL w1_release: got %0d bad releases, required 0", bad);
    end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    cin        = 1'b0;
    out_ready  = 1'b0;
    in_valid1  = 1'b0;
    a1         = 1'b0;
    b1         = 1'b0;
    cin1       = 1'b0;
    out_ready1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_carry_wrap();
    test_overflow();
    test_stall();
    test_reset_mid_run();
    test_back_to_back();
    test_width1();
    repeat (2) @(posedge clk);
    tests_run++;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
